// File: rtl/event_out_fifo.sv
// First-word-fall-through output FIFO for encoded AER events, with a registered head word,
// a saturating drop counter and a drain mode that blocks new events until the FIFO is empty.
module event_out_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12,
  parameter int CNT_W    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     evt_valid_i,
  input  logic [DATA_W-1:0]        evt_data_i,
  input  logic                     flush_i,
  input  logic                     drop_clr_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o,
  output logic                     flush_busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    drop_cnt_q;
  logic                overflow_q;
  logic                pop, accept, push, drop;

  assign valid_o       = (level_q != '0);
  assign full_o        = (level_q == LVL_W'(DEPTH));
  assign almost_full_o = (level_q >= LVL_W'(AFULL_TH));
  assign level_o       = level_q;
  assign data_o        = data_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign overflow_o    = overflow_q;
  assign flush_busy_o  = (state_q == DRAIN);

  // A full FIFO still takes a new word when the head leaves in the same cycle.
  assign pop        = valid_o && ready_i;
  assign accept     = evt_valid_i && (state_q == NORMAL);
  assign push       = accept && (!full_o || pop);
  assign drop       = accept && full_o && !pop;
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + 1'b1;
    else if (pop && !push)
      level_d = level_q - 1'b1;
  end

  // Next head word: at level 1 the successor is the word being written this cycle, not memory.
  always_comb begin
    data_d = data_q;
    if (pop) begin
      if (level_q == LVL_W'(1)) begin
        if (push)
          data_d = evt_data_i;
      end else begin
        data_d = mem[rd_ptr_nxt];
      end
    end else if (level_q == '0 && push) begin
      data_d = evt_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (flush_i) state_d = DRAIN;
      DRAIN:   if (level_d == '0) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr_q] <= evt_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      state_q  <= NORMAL;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_nxt;
      level_q <= level_d;
      data_q  <= data_d;
      state_q <= state_d;
    end
  end

  // A clear coinciding with a drop leaves that drop counted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (drop_clr_i) begin
      drop_cnt_q <= drop ? CNT_W'(1) : '0;
      overflow_q <= drop;
    end else if (drop) begin
      if (drop_cnt_q != '1)
        drop_cnt_q <= drop_cnt_q + 1'b1;
      overflow_q <= 1'b1;
    end
  end

endmodule
